// File: rtl/regf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regf_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port among
//            NUM_REQ writeback sources, each with a one-entry holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module regf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*5-1:0]  req_rd_addr,
    input  logic [NUM_REQ*32-1:0] req_rd_wdata,
    input  logic                  wb_stall,
    output logic                  regf_we,
    output logic [4:0]            rd_addr,
    output logic [31:0]           rd_wdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy
);

    localparam logic [PTR_W:0] c_num_req = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W:0] c_one     = (PTR_W+1)'(1);

    logic [NUM_REQ-1:0] r_buf_valid;
    logic [4:0]         r_buf_addr [NUM_REQ];
    logic [31:0]        r_buf_data [NUM_REQ];
    logic [PTR_W-1:0]   r_rr_ptr;

    logic [4:0]         w_in_addr [NUM_REQ];
    logic [31:0]        w_in_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_xfer;
    logic               w_found;
    logic               w_granted;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W:0]     w_cand;
    logic [PTR_W:0]     w_ptr_inc;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_in_addr[gi] = req_rd_addr[5*gi +: 5];
            assign w_in_data[gi] = req_rd_wdata[32*gi +: 32];
            // A granted buffer frees this cycle, so it can be refilled at once
            assign req_ready[gi] = !rst && (!r_buf_valid[gi] || grant[gi]);
            assign w_xfer[gi]    = req_valid[gi] && req_ready[gi];
        end
    endgenerate

    // Scan from the pointer downward in distance so the nearest valid wins
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (r_buf_valid[w_cand[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (!rst && !wb_stall && w_found) begin
            grant[w_sel] = 1'b1;
        end
    end

    assign w_granted = |grant;
    assign rd_addr   = w_granted ? r_buf_addr[w_sel] : 5'd0;
    assign rd_wdata  = w_granted ? r_buf_data[w_sel] : 32'd0;
    assign regf_we   = w_granted && (rd_addr != 5'd0);
    assign busy      = !rst && (|r_buf_valid);
    assign w_ptr_inc = {1'b0, w_sel} + c_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_granted) begin
                r_rr_ptr <= (w_ptr_inc == c_num_req) ? '0 : w_ptr_inc[PTR_W-1:0];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_xfer[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_addr[i]  <= w_in_addr[i];
                    r_buf_data[i]  <= w_in_data[i];
                end else if (grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_valid  : assert property (@(posedge clk) disable iff (rst) (grant & ~r_buf_valid) == '0);
    a_we_nonzero   : assert property (@(posedge clk) disable iff (rst) regf_we |-> (rd_addr != 5'd0));

endmodule
`default_nettype wire

// File: tb/tb_regf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regf_wb_arbiter
// Purpose  : Randomized and directed self-checking bench for regf_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regf_wb_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_rd_addr;
    logic [N*32-1:0] req_rd_wdata;
    logic            wb_stall;
    logic            regf_we;
    logic [4:0]      rd_addr;
    logic [31:0]     rd_wdata;
    logic [N-1:0]    grant;
    logic            busy;

    regf_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd_addr  (req_rd_addr),
        .req_rd_wdata (req_rd_wdata),
        .wb_stall     (wb_stall),
        .regf_we      (regf_we),
        .rd_addr      (rd_addr),
        .rd_wdata     (rd_wdata),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: each source holds at most one pending write
    bit          m_valid [N];
    logic [4:0]  m_addr  [N];
    logic [31:0] m_data  [N];
    int          m_wait  [N];
    int          m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic [N-1:0] v,
                         input logic [N*5-1:0] a, input logic [N*32-1:0] d);
        int          g;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        eb;
        @(negedge clk);
        rst = r; wb_stall = s; req_valid = v; req_rd_addr = a; req_rd_wdata = d;
        #2;
        g = -1;
        if (!r && !s) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && m_valid[j]) g = j;
            end
        end
        eg = '0; ea = '0; ed = '0; eb = 1'b0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea    = m_addr[g];
            ed    = m_data[g];
        end
        for (int i = 0; i < N; i++) begin
            if (m_valid[i]) eb = 1'b1;
            er[i] = !r && (!m_valid[i] || g == i);
        end
        if (r) eb = 1'b0;
        check("grant", grant, eg);
        check("req_ready", req_ready, er);
        check("rd_addr", rd_addr, ea);
        check("rd_wdata", rd_wdata, ed);
        check("regf_we", regf_we, (g >= 0) && (ea != 5'd0));
        check("busy", busy, eb);
        if (g >= 0) begin
            check("fair_wait", m_wait[g] <= N - 1, 1);
            for (int i = 0; i < N; i++) begin
                if (i != g && m_valid[i]) m_wait[i]++;
            end
            m_wait[g] = 0;
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (g == i) m_valid[i] = 1'b0;
                if (v[i] && er[i]) begin
                    m_valid[i] = 1'b1;
                    m_addr[i]  = a[5*i +: 5];
                    m_data[i]  = d[32*i +: 32];
                    m_wait[i]  = 0;
                end
            end
            if (g >= 0) m_ptr = (g + 1) % N;
        end
    endtask

    initial begin
        logic [N-1:0] exp_g;
        rst = 1'b1; wb_stall = 1'b0; req_valid = '0; req_rd_addr = '0; req_rd_wdata = '0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_wait[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        end
        m_ptr = 0;

        // reset state, including requests offered while in reset
        cycle(1'b1, 1'b0, '0, '0, '0);
        cycle(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});

        // single write
        cycle(1'b0, 1'b0, 3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF});
        #3;
        check("t1_grant", grant, 3'b001);
        check("t1_we", regf_we, 1'b1);
        check("t1_addr", rd_addr, 5'd5);
        check("t1_data", rd_wdata, 32'hDEADBEEF);
        cycle(1'b0, 1'b0, '0, '0, '0);
        #3;
        check("t1_busy", busy, 1'b0);

        // round robin with all sources held valid
        cycle(1'b1, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
            #3;
            exp_g = '0;
            exp_g[(k + 1) % N] = 1'b1;
            check("t2_rr", grant, exp_g);
        end

        // x0 destination drained without a write
        cycle(1'b1, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b0, 3'b010, '0, {32'd0, 32'h1234, 32'd0});
        #3;
        check("t3_grant", grant, 3'b010);
        check("t3_we", regf_we, 1'b0);
        check("t3_ready1", req_ready[1], 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0);

        // back-to-back stream from source 2
        cycle(1'b1, 1'b0, '0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 3'b100, {5'(4 + k), 10'd0}, {32'(100 + k), 64'd0});
            #3;
            check("t4_addr", rd_addr, 5'(4 + k));
            check("t4_ready2", req_ready[2], 1'b1);
        end
        cycle(1'b0, 1'b0, '0, '0, '0);

        // stall holds buffers and pointer
        cycle(1'b1, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b1, 3'b101, {5'd9, 5'd0, 5'd7}, {32'h9, 32'h0, 32'h7});
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, '0, '0, '0);
            #3;
            check("t5_grant", grant, 3'b000);
            check("t5_we", regf_we, 1'b0);
            check("t5_ready", req_ready, 3'b010);
        end
        wb_stall = 1'b0;
        #1;
        check("t5_resume", grant, 3'b001);
        cycle(1'b0, 1'b0, '0, '0, '0);

        // reset mid-operation discards buffered writes
        cycle(1'b0, 1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});
        cycle(1'b1, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b0, '0, '0, '0);
        #3;
        check("t6_busy", busy, 1'b0);
        check("t6_we", regf_we, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [N*5-1:0]  ra;
            logic [N*32-1:0] rd;
            for (int i = 0; i < N; i++) begin
                ra[5*i +: 5]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                rd[32*i +: 32] = $urandom;
            end
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0, N'($urandom), ra, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
